// File: rtl/mem_arbiter.sv
// Arbiter for the single-ported unified instruction/data memory, shared by fetch (IF) and load/store (D).
// Illegal requests are screened at grant time. Cycles in which a fetch waits are counted.
module mem_arbiter #(
    parameter int DATA_PRIO    = 1,
    parameter int TEXT_BASE    = 2048,
    parameter int PROTECT_TEXT = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_req,
    input  logic [11:0]      if_addr,
    output logic             if_ack,
    output logic [31:0]      if_rdata,
    output logic             if_err,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [2:0]       d_fun3,
    input  logic [11:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_ack,
    output logic [31:0]      d_rdata,
    output logic             d_err,
    output logic [60:0]      mem_in,
    input  logic [63:0]      mem_out,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic [12:0] FETCH_LIMIT = 13'(4096 - TEXT_BASE);
    localparam logic [12:0] TEXT_START  = 13'(TEXT_BASE);

    state_t           state_q, state_d;
    logic [11:0]      if_addr_q;
    logic             d_we_q;
    logic [2:0]       d_fun3_q;
    logic [11:0]      d_addr_q;
    logic [31:0]      d_wdata_q;
    logic             err_q, err_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      d_rdata_q, d_rdata_d;
    logic [CNT_W-1:0] stall_q;
    logic             pend_i, pend_d;
    logic             fetch_bad, load_bad, store_bad;

    // The requester acked in the ending cycle still shows its old req, so it is not pending.
    always_comb begin
        pend_i  = if_req && (state_q != GNT_I);
        pend_d  = d_req && (state_q != GNT_D);
        state_d = IDLE;
        if (pend_i && pend_d) begin
            state_d = (DATA_PRIO != 0) ? GNT_D : GNT_I;
        end else if (pend_i) begin
            state_d = GNT_I;
        end else if (pend_d) begin
            state_d = GNT_D;
        end
    end

    always_comb begin
        fetch_bad = (if_addr[1:0] != 2'b00) || ({1'b0, if_addr} >= FETCH_LIMIT);
        load_bad  = (d_fun3 == 3'd3) || (d_fun3 == 3'd6) || (d_fun3 == 3'd7);
        store_bad = (d_fun3 > 3'd2) ||
                    ((PROTECT_TEXT != 0) && ({1'b0, d_addr} >= TEXT_START));
        err_d = 1'b0;
        if (state_d == GNT_I) begin
            err_d = fetch_bad;
        end else if (state_d == GNT_D) begin
            err_d = d_we ? store_bad : load_bad;
        end
    end

    // A rejected grant keeps mem_in at zero so the memory never sees it.
    always_comb begin
        mem_in     = '0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            GNT_I: begin
                if (!err_q) begin
                    mem_in = {2'b00, if_addr_q, 47'd0};
                end
                if_rdata_d = err_q ? 32'd0 : mem_out[31:0];
            end
            GNT_D: begin
                if (!err_q) begin
                    mem_in = {~d_we_q, d_we_q, 12'd0, d_addr_q, d_fun3_q, d_wdata_q};
                end
                d_rdata_d = (err_q || d_we_q) ? 32'd0 : mem_out[63:32];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            err_q      <= 1'b0;
            if_addr_q  <= '0;
            d_we_q     <= 1'b0;
            d_fun3_q   <= '0;
            d_addr_q   <= '0;
            d_wdata_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if (state_d == GNT_I) begin
                if_addr_q <= if_addr;
            end
            if (state_d == GNT_D) begin
                d_we_q    <= d_we;
                d_fun3_q  <= d_fun3;
                d_addr_q  <= d_addr;
                d_wdata_q <= d_wdata;
            end
            if (if_req && (state_q != GNT_I) && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign if_ack    = (state_q == GNT_I);
    assign d_ack     = (state_q == GNT_D);
    assign if_err    = if_ack && err_q;
    assign d_err     = d_ack && err_q;
    assign if_rdata  = if_rdata_d;
    assign d_rdata   = d_rdata_d;
    assign busy      = (state_q != IDLE);
    assign stall_cnt = stall_q;

endmodule
